// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulus counter family (up and down variants).
// Holds the FSM state encoding and the default counter width.
package mod_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BITS_DEFAULT = 4;

endpackage

// File: rtl/mod_down_timer_if.sv
// Control/status bundle for mod_down_timer. All signals are sampled or updated on
// the rising edge of the timer clock; start/stop are level inputs read every cycle.
interface mod_down_timer_if
    import mod_counter_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
);

    logic            enable;
    logic            start;
    logic            stop;
    logic [BITS-1:0] load_value;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            done;
    state_t          dbg_state;

    modport master (
        output enable,
        output start,
        output stop,
        output load_value,
        input  Q,
        input  busy,
        input  done,
        input  dbg_state
    );

    modport slave (
        input  enable,
        input  start,
        input  stop,
        input  load_value,
        output Q,
        output busy,
        output done,
        output dbg_state
    );

endinterface

// File: rtl/mod_down_timer.sv
// Programmable-modulus down timer: loads load_value, counts to 0 on enabled cycles, pulses done.
// Define AUTO_RELOAD_EN to reload on expiry and run as a periodic tick instead of a one-shot.
module mod_down_timer
    import mod_counter_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    mod_down_timer_if.slave bus
);

    state_t          state_q, state_d;
    logic [BITS-1:0] q_q, q_d;
    logic            done_q, done_d;
    logic            q_zero;

    assign q_zero = (q_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    // Priority inside RUN: start (reload) > stop (abort) > terminal/decrement.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                q_d = '0;
                if (bus.start) begin
                    q_d     = bus.load_value;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    q_d = bus.load_value;
                end else if (bus.stop) begin
                    q_d     = '0;
                    state_d = IDLE;
                end else if (bus.enable) begin
                    if (!q_zero) begin
                        q_d = q_q - BITS'(1);
                    end else begin
                        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        q_d = bus.load_value;
`else
                        q_d     = '0;
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
            end
        endcase
    end

    assign bus.Q         = q_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mod_down_timer.sv
// Bench for mod_down_timer: vector table, directed corner sequences and random stimulus
// checked against a count-of-remaining-cycles reference model.
module tb_mod_down_timer;
    import mod_counter_pkg::*;

    localparam int BITS = 4;

    logic clk = 1'b0;
    logic reset;

    mod_down_timer_if #(.BITS(BITS)) bus();

    mod_down_timer #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m_left is the number of enabled RUN cycles still to go,
    // the last of which is the terminal cycle.
    bit m_run  = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0;

    typedef struct {
        bit en;
        bit st;
        bit sp;
        int lv;
        int q;
        bit b;
        bit d;
    } vec_t;

    vec_t tv[16];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit st, input bit sp, input int lv);
        int exp_q;
        reset          = rst;
        bus.enable     = en;
        bus.start      = st;
        bus.stop       = sp;
        bus.load_value = BITS'(lv);
        @(posedge clk);
        if (rst) begin
            m_run  = 1'b0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (st) begin
                m_run  = 1'b1;
                m_left = lv + 1;
            end else if (m_run && sp) begin
                m_run = 1'b0;
            end else if (m_run && en) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                    m_left = lv + 1;
`else
                    m_run = 1'b0;
`endif
                end
            end
        end
        exp_q = m_run ? (m_left - 1) : 0;
        @(negedge clk);
        check("model_q", int'(bus.Q), exp_q);
        check("model_busy", int'(bus.busy), int'(m_run));
        check("model_done", int'(bus.done), int'(m_done));
        check("model_state", int'(bus.dbg_state == RUN), int'(m_run));
    endtask

    initial begin
        int cnt;
        int en_cnt;
        bit seen;
        bit was_busy;
        bit en;

        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.load_value = '0;

        // Reset state, with start asserted to show reset wins.
        step(1, 1, 1, 0, 9);
        step(1, 0, 0, 0, 0);
        check("reset_q", int'(bus.Q), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);

        // Vector table: count 5, load 0, start in terminal cycle, stop handling.
        tv[0]  = '{1, 1, 0, 5, 5, 1, 0};
        tv[1]  = '{1, 0, 0, 5, 4, 1, 0};
        tv[2]  = '{1, 0, 0, 5, 3, 1, 0};
        tv[3]  = '{1, 0, 0, 5, 2, 1, 0};
        tv[4]  = '{1, 0, 0, 5, 1, 1, 0};
        tv[5]  = '{1, 0, 0, 5, 0, 1, 0};
`ifdef AUTO_RELOAD_EN
        tv[6]  = '{1, 0, 0, 5, 5, 1, 1};
`else
        tv[6]  = '{1, 0, 0, 5, 0, 0, 1};
`endif
        tv[7]  = '{1, 0, 1, 5, 0, 0, 0};
        tv[8]  = '{1, 1, 0, 0, 0, 1, 0};
        tv[9]  = '{1, 1, 0, 11, 11, 1, 0};
        tv[10] = '{0, 0, 0, 3, 11, 1, 0};
        tv[11] = '{1, 0, 1, 3, 0, 0, 0};
        tv[12] = '{1, 0, 1, 3, 0, 0, 0};
        tv[13] = '{1, 1, 0, 0, 0, 1, 0};
`ifdef AUTO_RELOAD_EN
        tv[14] = '{1, 0, 0, 9, 9, 1, 1};
`else
        tv[14] = '{1, 0, 0, 9, 0, 0, 1};
`endif
        tv[15] = '{0, 0, 1, 9, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step(0, tv[i].en, tv[i].st, tv[i].sp, tv[i].lv);
            check($sformatf("tbl%0d_q", i), int'(bus.Q), tv[i].q);
            check($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tv[i].b));
            check($sformatf("tbl%0d_done", i), int'(bus.done), int'(tv[i].d));
        end

        // Reset mid-RUN: load 9, three enabled cycles, then reset.
        step(0, 1, 1, 0, 9);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9);
        check("midrun_q_before", int'(bus.Q), 6);
        step(1, 1, 0, 0, 9);
        check("midrun_q", int'(bus.Q), 0);
        check("midrun_busy", int'(bus.busy), 0);
        check("midrun_done", int'(bus.done), 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 9);
            if (bus.done) seen = 1'b1;
        end
        check("midrun_no_done", int'(seen), 0);

        // Enable toggled every cycle with load 7: done after 8 enabled RUN cycles.
        step(0, 0, 1, 0, 7);
        en_cnt = 0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            en       = (k % 2 == 0);
            was_busy = bus.busy;
            step(0, en, 0, 0, 7);
            if (en && was_busy) en_cnt++;
            if (bus.done) seen = 1'b1;
        end
        check("toggle_done_seen", int'(seen), 1);
        check("toggle_enabled_cycles", en_cnt, 8);
        step(0, 0, 0, 1, 0);

        // Stop at Q=3 (load 6), then stop while idle.
        step(0, 1, 1, 0, 6);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 6);
        check("stop_q_before", int'(bus.Q), 3);
        step(0, 1, 0, 1, 6);
        check("stop_q", int'(bus.Q), 0);
        check("stop_busy", int'(bus.busy), 0);
        check("stop_done", int'(bus.done), 0);
        step(0, 1, 0, 1, 6);
        check("stop_idle_q", int'(bus.Q), 0);
        check("stop_idle_busy", int'(bus.busy), 0);

`ifdef AUTO_RELOAD_EN
        // Periodic tick: first period 6 cycles, load_value changed to 7 mid-period -> 8.
        step(0, 1, 1, 0, 5);
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(0, 1, 0, 0, (k >= 2) ? 7 : 5);
            cnt++;
            if (bus.done) seen = 1'b1;
        end
        check("auto_first_period", cnt, 6);
        for (int p = 0; p < 2; p++) begin
            cnt = 0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                step(0, 1, 0, 0, 7);
                cnt++;
                if (bus.done) seen = 1'b1;
            end
            check("auto_next_period", cnt, 8);
        end
        step(0, 1, 0, 1, 7);
        check("auto_stop_busy", int'(bus.busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 7);
            if (bus.done) seen = 1'b1;
        end
        check("auto_stop_no_done", int'(seen), 0);
`endif

        // Random stimulus against the reference model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < 6),
                 ($urandom_range(0, 99) < 4),
                 int'($urandom_range(0, (1 << BITS) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
